// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: fetch/mem request-response and SRAM macro bus bundle
interface sram_arbiter_if;
  logic cancel, inst_req, inst_gnt, inst_rvalid;
  logic data_req, data_gnt, data_rvalid, sram_en;
  logic [3:0] data_wen, sram_wen;
  logic [31:0] inst_addr, inst_rdata, data_addr, data_wdata, data_rdata;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  modport master(
    output cancel, inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata, sram_rdata,
    input inst_gnt, inst_rvalid, inst_rdata, data_gnt, data_rvalid, data_rdata,
    input sram_en, sram_wen, sram_addr, sram_wdata
  );
  modport slave(
    input cancel, inst_req, inst_addr, data_req, data_wen, data_addr, data_wdata, sram_rdata,
    output inst_gnt, inst_rvalid, inst_rdata, data_gnt, data_rvalid, data_rdata,
    output sram_en, sram_wen, sram_addr, sram_wdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one 1-cycle-latency SRAM between fetch and mem stage, data-first with starvation bound
module sram_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input logic clk,
  input logic reset,
  sram_arbiter_if.slave bus
);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  typedef enum logic [1:0] {IDLE, INST_RD, DATA_RD} owner_t;
  owner_t owner, owner_nxt;
  logic [3:0] starve_cnt, starve_nxt;
  logic igt, dgt;
  always_comb begin
    igt = bus.inst_req & ~bus.cancel & ~reset & (~bus.data_req | starve_cnt == SMAX);
    dgt = bus.data_req & ~reset & ~igt;
    owner_nxt = igt ? INST_RD : (dgt && bus.data_wen == 4'd0) ? DATA_RD : IDLE;
    // a cancelled inst request that loses to data leaves the count unchanged
    starve_nxt = (igt | ~bus.inst_req) ? 4'd0 :
                 (dgt & ~bus.cancel & starve_cnt != SMAX) ? starve_cnt + 4'd1 : starve_cnt;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      owner <= IDLE;
      starve_cnt <= 4'd0;
    end else begin
      owner <= owner_nxt;
      starve_cnt <= starve_nxt;
    end
  end
  assign bus.inst_gnt = igt;
  assign bus.data_gnt = dgt;
  assign bus.sram_en = igt | dgt;
  assign bus.sram_addr = dgt ? bus.data_addr : igt ? bus.inst_addr : 32'd0;
  assign bus.sram_wen = dgt ? bus.data_wen : 4'd0;
  assign bus.sram_wdata = dgt ? bus.data_wdata : 32'd0;
  assign bus.inst_rvalid = owner == INST_RD && !bus.cancel && !reset;
  assign bus.data_rvalid = owner == DATA_RD && !reset;
  assign bus.inst_rdata = bus.sram_rdata;
  assign bus.data_rdata = bus.sram_rdata;
endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed and random checks of sram_arbiter against a behavioural model
module tb_sram_arbiter;
  localparam int SMAX = 4;
  logic clk, reset;
  int checks = 0, errors = 0;
  int m_starve = 0, m_pend = 0;
  logic e_igt, e_dgt;
  sram_arbiter_if bus();
  sram_arbiter #(.STARVE_MAX(SMAX)) dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 0;
  always #5 clk = ~clk;
  task chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task step(input logic r, input logic c, input logic ir, input logic [31:0] ia, input logic dr,
            input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd, input logic [31:0] sr);
    reset = r; bus.cancel = c; bus.inst_req = ir; bus.inst_addr = ia; bus.data_req = dr;
    bus.data_wen = dw; bus.data_addr = da; bus.data_wdata = dd; bus.sram_rdata = sr;
    @(negedge clk);
    e_igt = !r && ir && !c && (!dr || m_starve == SMAX);
    e_dgt = !r && dr && !e_igt;
    chk("inst_gnt", bus.inst_gnt, e_igt);
    chk("data_gnt", bus.data_gnt, e_dgt);
    chk("sram_en", bus.sram_en, e_igt || e_dgt);
    chk("sram_addr", bus.sram_addr, e_dgt ? da : e_igt ? ia : 0);
    chk("sram_wen", bus.sram_wen, e_dgt ? dw : 0);
    chk("sram_wdata", bus.sram_wdata, e_dgt ? dd : 0);
    chk("inst_rvalid", bus.inst_rvalid, !r && !c && m_pend == 1);
    chk("data_rvalid", bus.data_rvalid, !r && m_pend == 2);
    chk("inst_rdata", bus.inst_rdata, sr);
    chk("data_rdata", bus.data_rdata, sr);
    chk("starve_cnt", dut.starve_cnt, m_starve);
  endtask
  task tick;
    if (reset) begin
      m_pend = 0;
      m_starve = 0;
    end else begin
      m_pend = e_igt ? 1 : (e_dgt && bus.data_wen == 0) ? 2 : 0;
      if (e_igt || !bus.inst_req) m_starve = 0;
      else if (e_dgt && !bus.cancel && m_starve < SMAX) m_starve++;
    end
    @(posedge clk);
    #1;
  endtask
  task idle;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask
  initial begin
    step(1, 0, 1, 32'h40, 1, 0, 32'h80, 0, 32'h55);
    chk("reset_igt", bus.inst_gnt, 0);
    chk("reset_dgt", bus.data_gnt, 0);
    chk("reset_en", bus.sram_en, 0);
    tick();
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    // fetch-only stream
    for (int i = 0; i < 4; i++) begin
      step(0, 0, i < 3, 32'(4 * i), 0, 0, 0, 0, i == 0 ? 32'h0 : 32'(32'hA0 + i - 1));
      if (i < 3) chk("fetch_gnt", bus.inst_gnt, 1);
      if (i > 0) begin
        chk("fetch_rvalid", bus.inst_rvalid, 1);
        chk("fetch_rdata", bus.inst_rdata, 32'hA0 + 32'(i - 1));
      end
      tick();
    end
    idle();
    // starvation bound
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, 32'h200, 1, 0, 32'h300, 0, 32'(i));
      chk("starve_seq", dut.starve_cnt, i == 5 ? 0 : i);
      chk("starve_igt", bus.inst_gnt, i == 4);
      chk("starve_dgt", bus.data_gnt, i != 4);
      tick();
    end
    idle();
    idle();
    // store
    step(0, 0, 0, 0, 1, 4'b0011, 32'h100, 32'h12345678, 0);
    chk("store_en", bus.sram_en, 1);
    chk("store_wen", bus.sram_wen, 4'b0011);
    chk("store_addr", bus.sram_addr, 32'h100);
    tick();
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD);
    chk("store_no_rvalid", bus.data_rvalid, 0);
    tick();
    // cancel on response
    step(0, 0, 1, 32'h10, 0, 0, 0, 0, 0);
    tick();
    step(0, 1, 1, 32'h14, 1, 0, 32'h20, 0, 32'hBEEF);
    chk("cancel_irv", bus.inst_rvalid, 0);
    chk("cancel_igt", bus.inst_gnt, 0);
    chk("cancel_dgt", bus.data_gnt, 1);
    tick();
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'hCAFE);
    chk("cancel_drv", bus.data_rvalid, 1);
    tick();
    // reset mid-read
    step(0, 0, 0, 0, 1, 0, 32'h30, 0, 0);
    tick();
    step(1, 0, 1, 32'h34, 1, 0, 32'h38, 0, 32'h77);
    chk("rst_drv", bus.data_rvalid, 0);
    chk("rst_igt", bus.inst_gnt, 0);
    chk("rst_dgt", bus.data_gnt, 0);
    tick();
    step(0, 0, 1, 32'h34, 1, 0, 32'h38, 0, 0);
    chk("rst_resume_dgt", bus.data_gnt, 1);
    chk("rst_resume_cnt", dut.starve_cnt, 0);
    tick();
    idle();
    // mixed back-to-back
    step(0, 0, 0, 0, 1, 0, 32'h40, 0, 0);
    tick();
    step(0, 0, 1, 32'h44, 0, 0, 0, 0, 32'h11);
    chk("mix_drv", bus.data_rvalid, 1);
    tick();
    step(0, 0, 0, 0, 1, 4'hF, 32'h48, 32'h99, 32'h22);
    chk("mix_irv", bus.inst_rvalid, 1);
    tick();
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h33);
    chk("mix_none", {bus.inst_rvalid, bus.data_rvalid}, 0);
    tick();
    // random traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(49) == 0, $urandom_range(5) == 0, 1'($urandom), $urandom, 1'($urandom),
           $urandom_range(1) == 0 ? 4'd0 : 4'($urandom), $urandom, $urandom, $urandom);
      tick();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
